// File: rtl/bfp_frame_exponent_pkg.sv
// Shared definitions for the block-floating-point exponent path: control states
// and the exponent width shared with the downstream right-shift scaler.
package bfp_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Width of the exponent / shift-magnitude bus for a given frame length.
    function automatic int exp_width(input int nfft);
        return $clog2(nfft) + 1;
    endfunction

endpackage

// File: rtl/bfp_frame_exponent_sign_headroom.sv
// Combinational redundant-sign-bit counter: number of leading bits equal to the
// sign bit, minus one (0 .. DATA_WIDTH-1).
module sign_headroom #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0]         i_data,
    output logic [$clog2(DATA_WIDTH)-1:0] o_headroom
);

    localparam int HW = $clog2(DATA_WIDTH);

    logic [HW-1:0] w_count;
    logic          w_run;

    // Walk down from just below the sign bit until the first bit that differs.
    always_comb begin
        w_count = '0;
        w_run   = 1'b1;
        for (int k = DATA_WIDTH - 2; k >= 0; k--) begin
            if (w_run && (i_data[k] == i_data[DATA_WIDTH-1])) begin
                w_count = w_count + HW'(1);
            end else begin
                w_run = 1'b0;
            end
        end
    end

    assign o_headroom = w_count;

endmodule

// File: rtl/bfp_frame_exponent.sv
// Per-frame block-floating-point exponent detector: tracks the minimum sign
// headroom over NFFT complex samples and publishes it once per frame.
module bfp_frame_exponent
    import bfp_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NFFT       = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_in,
    input  logic                        sof_in,
    input  logic signed [DATA_WIDTH-1:0] data_in_r,
    input  logic signed [DATA_WIDTH-1:0] data_in_i,
    output logic [exp_width(NFFT)-1:0]  exp_out,
    output logic                        exp_valid,
    output logic                        busy
);

    localparam int            CW       = $clog2(NFFT);
    localparam int            HW       = $clog2(DATA_WIDTH);
    localparam int            EW       = exp_width(NFFT);
    localparam logic [CW-1:0] LAST_IDX = CW'(NFFT - 1);
    localparam logic [HW-1:0] HR_MAX   = HW'(DATA_WIDTH - 1);

    logic [CW-1:0]         r_count;
    state_t                r_state;
    logic                  w_last;

    logic                  r_acc_valid;
    logic                  r_acc_last;
    logic                  r_acc_sof;
    logic [DATA_WIDTH-1:0] r_acc_r;
    logic [DATA_WIDTH-1:0] r_acc_i;

    logic                  r_s1_valid;
    logic                  r_s1_last;
    logic                  r_s1_sof;
    logic [DATA_WIDTH-1:0] r_s1_r;
    logic [DATA_WIDTH-1:0] r_s1_i;

    logic [HW-1:0]         r_min;
    logic [HW-1:0]         w_hr_r;
    logic [HW-1:0]         w_hr_i;
    logic [HW-1:0]         w_hr_sample;
    logic [HW-1:0]         w_base;
    logic [HW-1:0]         w_merged;

    // A resync sample is always index 0, so it can never close a frame.
    assign w_last = !sof_in && (r_count == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_state <= IDLE;
        end else if (valid_in) begin
            if (sof_in) begin
                r_count <= CW'(1);
                r_state <= ACCUM;
            end else begin
                r_count <= r_count + CW'(1);
                r_state <= w_last ? IDLE : ACCUM;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_valid <= 1'b0;
            r_acc_last  <= 1'b0;
            r_acc_sof   <= 1'b0;
            r_acc_r     <= '0;
            r_acc_i     <= '0;
        end else begin
            r_acc_valid <= valid_in;
            if (valid_in) begin
                r_acc_last <= w_last;
                r_acc_sof  <= sof_in;
                r_acc_r    <= data_in_r;
                r_acc_i    <= data_in_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s1_r     <= '0;
            r_s1_i     <= '0;
        end else begin
            r_s1_valid <= r_acc_valid;
            r_s1_last  <= r_acc_last;
            r_s1_sof   <= r_acc_sof;
            r_s1_r     <= r_acc_r;
            r_s1_i     <= r_acc_i;
        end
    end

    sign_headroom #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_headroom_r (
        .i_data    (r_s1_r),
        .o_headroom(w_hr_r)
    );

    sign_headroom #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_headroom_i (
        .i_data    (r_s1_i),
        .o_headroom(w_hr_i)
    );

    assign w_hr_sample = (w_hr_r < w_hr_i) ? w_hr_r : w_hr_i;
    assign w_base      = r_s1_sof ? HR_MAX : r_min;
    assign w_merged    = (w_hr_sample < w_base) ? w_hr_sample : w_base;

    // The closing sample publishes and reloads in the same edge, so a following
    // frame's first sample always merges into a fresh minimum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min     <= HR_MAX;
            exp_out   <= '0;
            exp_valid <= 1'b0;
        end else begin
            exp_valid <= 1'b0;
            if (r_s1_valid) begin
                if (r_s1_last) begin
                    exp_out   <= EW'(w_merged);
                    exp_valid <= 1'b1;
                    r_min     <= HR_MAX;
                end else begin
                    r_min <= w_merged;
                end
            end
        end
    end

    assign busy = (r_state == ACCUM);

endmodule

// File: tb/tb_bfp_frame_exponent.sv
// Self-checking bench for bfp_frame_exponent: table-driven frames plus resync,
// gap and reset sequences, with a pulse-timing scoreboard.
module tb_bfp_frame_exponent;

    localparam int DW   = 16;
    localparam int NFFT = 8;
    localparam int EW   = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 valid_in;
    logic                 sof_in;
    logic signed [DW-1:0] data_in_r;
    logic signed [DW-1:0] data_in_i;
    logic [EW-1:0]        exp_out;
    logic                 exp_valid;
    logic                 busy;

    always #5 clk = ~clk;

    bfp_frame_exponent #(
        .DATA_WIDTH(DW),
        .NFFT      (NFFT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .sof_in   (sof_in),
        .data_in_r(data_in_r),
        .data_in_i(data_in_i),
        .exp_out  (exp_out),
        .exp_valid(exp_valid),
        .busy     (busy)
    );

    typedef struct {
        int            due;
        logic [EW-1:0] value;
    } expect_t;

    typedef struct {
        int            idxA;
        logic [DW-1:0] reA;
        logic [DW-1:0] imA;
        int            idxB;
        logic [DW-1:0] reB;
        logic [DW-1:0] imB;
        logic [EW-1:0] expected;
    } frameVec_t;

    expect_t   sbQueue[$];
    frameVec_t vecs[12];
    int        nPass  = 0;
    int        nTotal = 0;
    int        cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input int actual, input int required);
        nTotal++;
        if (actual == required) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    // Drive one cycle of inputs; a closing sample queues its expected exponent,
    // due on the negedge after the third following rising edge.
    task automatic applyStimulus(input logic v, input logic sof, input logic [DW-1:0] r,
                                 input logic [DW-1:0] i, input logic pushIt,
                                 input logic [EW-1:0] expVal);
        expect_t e;
        @(negedge clk);
        valid_in  = v;
        sof_in    = sof;
        data_in_r = r;
        data_in_i = i;
        if (pushIt) begin
            e.due   = cyc + 3;
            e.value = expVal;
            sbQueue.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic sendFrame(input frameVec_t fv, input int maxGap);
        logic [DW-1:0] r;
        logic [DW-1:0] i;
        for (int k = 0; k < NFFT; k++) begin
            r = '0;
            i = '0;
            if (k == fv.idxA) begin
                r = fv.reA;
                i = fv.imA;
            end
            if (k == fv.idxB) begin
                r = fv.reB;
                i = fv.imB;
            end
            if (maxGap > 0) begin
                repeat ($urandom_range(1, maxGap))
                    applyStimulus(1'b0, 1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom), 1'b0, '0);
            end
            applyStimulus(1'b1, 1'b0, r, i, k == NFFT - 1, fv.expected);
            if (maxGap > 0) begin
                checkOutput($sformatf("gap_busy_k%0d", k), int'(busy), (k < NFFT - 1) ? 1 : 0);
            end
        end
    endtask

    always @(negedge clk) begin
        expect_t e;
        if (exp_valid) begin
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected_pulse", int'(exp_valid), 0);
            end else begin
                e = sbQueue.pop_front();
                checkOutput("pulse_cycle", cyc, e.due);
                checkOutput("exp_out", int'(exp_out), int'(e.value));
            end
        end else if (sbQueue.size() > 0 && cyc > sbQueue[0].due) begin
            e = sbQueue.pop_front();
            checkOutput("missing_pulse", cyc, e.due);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{idxA: 0, reA: 16'h0000, imA: 16'h0000, idxB: 1, reB: 16'h0000, imB: 16'h0000, expected: 4'd15};
        vecs[1]  = '{idxA: 4, reA: 16'h0800, imA: 16'h0000, idxB: 9, reB: 16'h0000, imB: 16'h0000, expected: 4'd3};
        vecs[2]  = '{idxA: 3, reA: 16'h0100, imA: 16'h0000, idxB: 5, reB: 16'h0000, imB: 16'hFF00, expected: 4'd6};
        vecs[3]  = '{idxA: 5, reA: 16'h0000, imA: 16'hFF00, idxB: 9, reB: 16'h0000, imB: 16'h0000, expected: 4'd7};
        vecs[4]  = '{idxA: 0, reA: 16'h4000, imA: 16'h0000, idxB: 9, reB: 16'h0000, imB: 16'h0000, expected: 4'd0};
        vecs[5]  = '{idxA: 7, reA: 16'h0000, imA: 16'h8000, idxB: 9, reB: 16'h0000, imB: 16'h0000, expected: 4'd0};
        vecs[6]  = '{idxA: 1, reA: 16'hFFFF, imA: 16'hFFFF, idxB: 9, reB: 16'h0000, imB: 16'h0000, expected: 4'd15};
        vecs[7]  = '{idxA: 6, reA: 16'h0001, imA: 16'h0000, idxB: 9, reB: 16'h0000, imB: 16'h0000, expected: 4'd14};
        vecs[8]  = '{idxA: 2, reA: 16'h0000, imA: 16'hC000, idxB: 9, reB: 16'h0000, imB: 16'h0000, expected: 4'd1};
        vecs[9]  = '{idxA: 3, reA: 16'h3FFF, imA: 16'h0000, idxB: 4, reB: 16'h0000, imB: 16'hFFFE, expected: 4'd1};
        vecs[10] = '{idxA: 7, reA: 16'hFE00, imA: 16'h0000, idxB: 0, reB: 16'h0000, imB: 16'h0200, expected: 4'd5};
        vecs[11] = '{idxA: 0, reA: 16'h7FFF, imA: 16'h0000, idxB: 7, reB: 16'h0000, imB: 16'h0000, expected: 4'd0};

        rst       = 1'b1;
        valid_in  = 1'b0;
        sof_in    = 1'b0;
        data_in_r = '0;
        data_in_i = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_exp_out", int'(exp_out), 0);
        checkOutput("reset_exp_valid", int'(exp_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;

        // All table frames run back-to-back with no idle cycles between them.
        for (int v = 0; v < 12; v++) begin
            sendFrame(vecs[v], 0);
        end
        idleCycles(4);
        checkOutput("idle_busy", int'(busy), 0);

        sendFrame(vecs[2], 4);
        idleCycles(5);

        // Aborted frame: 0x4000 at index 2 must not leak into the resynced frame.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b0, (k == 2) ? 16'h4000 : 16'h0000, '0, 1'b0, '0);
        end
        checkOutput("abort_busy_mid", int'(busy), 1);
        for (int k = 0; k < NFFT; k++) begin
            applyStimulus(1'b1, k == 0, '0, '0, k == NFFT - 1, 4'd15);
        end
        idleCycles(5);
        checkOutput("abort_queue_empty", sbQueue.size(), 0);

        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, 16'h4000, 16'h4000, 1'b0, '0);
        end
        checkOutput("busy_before_rst", int'(busy), 1);
        @(negedge clk);
        valid_in  = 1'b1;
        data_in_r = 16'h4000;
        data_in_i = 16'h4000;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_exp_out", int'(exp_out), 0);
        checkOutput("midrst_exp_valid", int'(exp_valid), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        valid_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < NFFT; k++) begin
            applyStimulus(1'b1, 1'b0, 16'h0100, 16'h0100, k == NFFT - 1, 4'd6);
        end
        idleCycles(6);
        checkOutput("final_queue_empty", sbQueue.size(), 0);
        checkOutput("final_busy", int'(busy), 0);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
